// File: rtl/arf074b032e1r1w0cbbehsaa4acw_init_seq.sv
// Register-file clear sequencer: on a synchronized init request, zero-writes every entry
// in ascending order, then holds a 4-phase acknowledge until the request drops.
module arf074b032e1r1w0cbbehsaa4acw_init_seq #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned WIDTH  = 74,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              init_req_sync,
    output logic              init_ack,
    output logic              init_busy,
    output logic              init_wr_en,
    output logic [ADDR_W-1:0] init_wr_addr,
    output logic [WIDTH-1:0]  init_wr_data,
    output logic              init_done
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSweep = 2'd1,
        StAck   = 2'd2
    } state_e;

    // Terminal count compare rather than overflow, so non-power-of-two depths stop exactly.
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_e            state;
    logic [ADDR_W-1:0] counter;
    logic              done;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state   <= StIdle;
            counter <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                // Ack is always low in idle, so a high request alone starts a sweep.
                StIdle: begin
                    if (init_req_sync) begin
                        state   <= StSweep;
                        counter <= '0;
                    end
                end
                // The request is deliberately ignored here; a sweep always runs to completion.
                StSweep: begin
                    if (counter == LastAddr) begin
                        state   <= StAck;
                        counter <= '0;
                        done    <= 1'b1;
                    end else begin
                        counter <= counter + ADDR_W'(1);
                    end
                end
                StAck: begin
                    if (!init_req_sync) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state   <= StIdle;
                    counter <= '0;
                end
            endcase
        end
    end

    assign init_wr_en   = (state == StSweep);
    assign init_wr_addr = counter;
    assign init_wr_data = '0;
    assign init_busy    = (state != StIdle);
    assign init_ack     = (state == StAck);
    assign init_done    = done;

endmodule

// File: tb/tb_arf074b032e1r1w0cbbehsaa4acw_init_seq.sv
// Directed bench for the clear sequencer: a 32-entry and a 20-entry instance, write
// addresses checked against a queue of expected addresses filled when requests are raised.
module tb_arf074b032e1r1w0cbbehsaa4acw_init_seq;

    logic        clk;
    logic        rst_b;
    logic        req32;
    logic        req20;

    logic        ack32, busy32, wr_en32, done32;
    logic [4:0]  addr32;
    logic [73:0] data32;
    logic        ack20, busy20, wr_en20, done20;
    logic [4:0]  addr20;
    logic [73:0] data20;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned q32[$];
    int unsigned q20[$];

    arf074b032e1r1w0cbbehsaa4acw_init_seq #(.DEPTH(32), .WIDTH(74)) dut32 (
        .clk          (clk),
        .rst_b        (rst_b),
        .init_req_sync(req32),
        .init_ack     (ack32),
        .init_busy    (busy32),
        .init_wr_en   (wr_en32),
        .init_wr_addr (addr32),
        .init_wr_data (data32),
        .init_done    (done32)
    );

    arf074b032e1r1w0cbbehsaa4acw_init_seq #(.DEPTH(20), .WIDTH(74)) dut20 (
        .clk          (clk),
        .rst_b        (rst_b),
        .init_req_sync(req20),
        .init_ack     (ack20),
        .init_busy    (busy20),
        .init_wr_en   (wr_en20),
        .init_wr_addr (addr20),
        .init_wr_data (data20),
        .init_done    (done20)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected address.
    always @(negedge clk) begin
        if (wr_en32) begin
            if (q32.size() == 0) begin
                check("wr32_unexpected_qsize", 32'(q32.size()), 32'd1);
            end else begin
                check("wr32_addr", 32'(addr32), q32.pop_front());
                check("wr32_data_zero", 32'(data32 == '0), 32'd1);
            end
        end
        if (wr_en20) begin
            if (q20.size() == 0) begin
                check("wr20_unexpected_qsize", 32'(q20.size()), 32'd1);
            end else begin
                check("wr20_addr", 32'(addr20), q20.pop_front());
                check("wr20_data_zero", 32'(data20 == '0), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push32(input int unsigned last);
        for (int unsigned a = 0; a <= last; a++) q32.push_back(a);
    endtask

    // Request already high before the next posedge; runs 32 write cycles plus the ack cycle.
    task automatic check_sweep32(input int drop_at);
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            check("sweep_wr_en", 32'(wr_en32), 32'd1);
            check("sweep_busy", 32'(busy32), 32'd1);
            check("sweep_ack", 32'(ack32), 32'd0);
            if (c == drop_at) req32 = 1'b0;
        end
        @(negedge clk);
        check("ack_cycle_ack", 32'(ack32), 32'd1);
        check("ack_cycle_wr_en", 32'(wr_en32), 32'd0);
        check("ack_cycle_done", 32'(done32), 32'd1);
        check("sweep_q_empty", 32'(q32.size()), 32'd0);
    endtask

    initial begin
        rst_b = 1'b0;
        req32 = 1'b0;
        req20 = 1'b0;
        #3;
        check("rst_ack", 32'(ack32), 32'd0);
        check("rst_busy", 32'(busy32), 32'd0);
        check("rst_wr_en", 32'(wr_en32), 32'd0);
        check("rst_addr", 32'(addr32), 32'd0);
        check("rst_done", 32'(done32), 32'd0);
        check("rst_data_zero", 32'(data32 == '0), 32'd1);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy32), 32'd0);

        // Basic sweep, then request held high for 10 cycles must not retrigger.
        req32 = 1'b1;
        push32(31);
        check_sweep32(0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("hold_ack", 32'(ack32), 32'd1);
            check("hold_wr_en", 32'(wr_en32), 32'd0);
        end
        req32 = 1'b0;
        @(negedge clk);
        check("drop_ack", 32'(ack32), 32'd0);
        check("drop_busy", 32'(busy32), 32'd0);
        check("drop_done_sticky", 32'(done32), 32'd1);

        // Second full 4-phase cycle.
        req32 = 1'b1;
        push32(31);
        check_sweep32(0);
        req32 = 1'b0;
        @(negedge clk);
        check("second_ack_drop", 32'(ack32), 32'd0);

        // Request falls at write 5: sweep completes, ack lasts exactly one cycle.
        req32 = 1'b1;
        push32(31);
        check_sweep32(5);
        @(negedge clk);
        check("pulse_ack_one_cycle", 32'(ack32), 32'd0);
        check("pulse_busy", 32'(busy32), 32'd0);
        @(negedge clk);
        check("pulse_no_restart", 32'(wr_en32), 32'd0);

        // Reset at address 17 aborts asynchronously; sweep restarts from 0 after release.
        req32 = 1'b1;
        push32(17);
        for (int c = 1; c <= 18; c++) @(negedge clk);
        check("pre_rst_addr", 32'(addr32), 32'd17);
        #2 rst_b = 1'b0;
        #1;
        check("async_rst_wr_en", 32'(wr_en32), 32'd0);
        check("async_rst_busy", 32'(busy32), 32'd0);
        check("async_rst_done", 32'(done32), 32'd0);
        check("async_rst_addr", 32'(addr32), 32'd0);
        check("abort_q_empty", 32'(q32.size()), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        push32(31);
        check_sweep32(0);
        req32 = 1'b0;
        @(negedge clk);
        check("restart_ack_drop", 32'(ack32), 32'd0);

        // Non-power-of-two depth: exactly 20 writes, ack in cycle 21.
        check("d20_idle_busy", 32'(busy20), 32'd0);
        req20 = 1'b1;
        for (int unsigned a = 0; a < 20; a++) q20.push_back(a);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            check("d20_wr_en", 32'(wr_en20), 32'd1);
            check("d20_ack", 32'(ack20), 32'd0);
        end
        @(negedge clk);
        check("d20_ack_cycle", 32'(ack20), 32'd1);
        check("d20_wr_en_off", 32'(wr_en20), 32'd0);
        check("d20_done", 32'(done20), 32'd1);
        check("d20_q_empty", 32'(q20.size()), 32'd0);
        req20 = 1'b0;
        @(negedge clk);
        check("d20_ack_drop", 32'(ack20), 32'd0);
        check("d32_quiet", 32'(busy32), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
